controle_calculadora: RTL and testbench
=======================================

CONTROLE_CALCULADORA -- requirements
Module: controle_calculadora

Interface
REQ-001 The block SHALL have exactly one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 The block SHALL have these ports, one per line (name  direction  width  meaning):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- entrada  in  8  operand magnitude from switches.
- sinal_entrada  in  1  operand sign from switch (1 = negative).
- op_entrada  in  3  operation code from switches: 100 add, 010 subtract, 001 multiply.
- botao_enter  in  1  level input, already debounced; its rising edge confirms the current entry.
- botao_limpa  in  1  level input; while high, aborts the sequence and returns to operand A entry.
- a, b  out  8 each  operand magnitudes driven to the calculator datapath.
- sinal_a, sinal_b  out  1 each  operand signs driven to the calculator.
- sel  out  3  operation select driven to the calculator.
- saida_calc  in  16  combinational result magnitude from the calculator.
- sinal_calc  in  1  combinational result sign from the calculator.
- resultado  out  16  registered result magnitude for display.
- sinal_resultado  out  1  registered result sign.
- pronto  out  1  high while a valid result is held.
- erro  out  1  one-cycle pulse on an invalid op_entrada.
- estado  out  3  current state code, used by the LCD driver for prompts.

Function
REQ-003 The FSM SHALL have these states: ESPERA_A, ESPERA_B, ESPERA_OP, CALCULA, MOSTRA.
REQ-004 A confirm event SHALL be the rising edge of botao_enter, detected as (current high AND previous-cycle low); holding the button SHALL produce exactly one confirm event.
REQ-005 ESPERA_A on confirm: latch entrada into a and sinal_entrada into sinal_a, then go to ESPERA_B.
REQ-006 ESPERA_B on confirm: latch entrada into b and sinal_entrada into sinal_b, then go to ESPERA_OP.
REQ-007 ESPERA_OP on confirm with op_entrada equal to 100, 010 or 001: latch it into sel, then go to CALCULA.
REQ-008 ESPERA_OP on confirm with any other op_entrada: sel stays 000, erro pulses high for one cycle, and the state stays ESPERA_OP.
REQ-009 CALCULA SHALL last exactly one cycle; on exit it SHALL capture saida_calc and sinal_calc into resultado and sinal_resultado, set pronto, and go to MOSTRA.
REQ-010 Latency: resultado SHALL be valid 2 cycles after the op-confirm edge is sampled.
REQ-011 Zero normalisation: if the captured saida_calc is 0, sinal_resultado SHALL be forced to 0 (no negative zero).
REQ-012 MOSTRA on confirm: clear pronto and sel, keep resultado, go to ESPERA_A.
- a, b, sinal_a and sinal_b retain their values until overwritten by new entries.
REQ-013 While not in CALCULA or MOSTRA, sel SHALL be 000, so the calculator outputs 0.
REQ-014 botao_limpa high SHALL take priority over confirm in every state: next state ESPERA_A, pronto=0, sel=000; a, b and resultado are unchanged.
REQ-015 A confirm in the same cycle as a state's entry SHALL be honoured only if it is a new rising edge; no events SHALL be queued.
REQ-016 The estado codes SHALL be: ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, CALCULA=3, MOSTRA=4.
REQ-017 Operands SHALL be unsigned 8-bit magnitudes with a separate sign bit; the block SHALL perform no arithmetic other than the zero check.

Reset
REQ-018 On rst=1 at a clock edge, the block SHALL load: state ESPERA_A; a=b=0; sinal_a=sinal_b=0; sel=000; resultado=0; sinal_resultado=0; pronto=0; erro=0.
- The edge-detector history SHALL be set to 1, so a button held through reset does not confirm.
REQ-019 Reset asserted mid-sequence, including in CALCULA, SHALL discard the in-flight operation with no capture.

Structure
REQ-020 State encodings and the op constants (OP_SOMA=100, OP_SUB=010, OP_MUL=001) SHALL live in the shared package calc_pkg.
REQ-021 The rising-edge detection SHALL be one sub-module, detector_borda; the calculator is instantiated outside this block.

Verification
REQ-022 The bench SHALL cover at least these directed scenarios (stimulus -> required response):
- A=+25, B=-10, op 100, calculator model attached -> resultado=15, sinal_resultado=0, pronto high 2 cycles after the op edge.
- A=-12, B=+12, op 100 -> resultado=0, sinal_resultado=0 (zero normalisation).
- A=+200, B=-255, op 001 -> resultado=51000, sinal_resultado=1.
- op_entrada=011 confirmed -> erro pulses for 1 cycle, estado stays 2, sel=000; then op 010 -> proceeds to CALCULA.
- botao_enter held high for 10 cycles in ESPERA_A -> exactly one advance, to estado 1.
- botao_limpa and a confirm edge in the same cycle in ESPERA_OP -> estado 0; then rst pulse in MOSTRA -> all outputs return to reset values.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encodings and operation codes for the calculator control
package calc_pkg;

   typedef enum logic [2:0] {
      ESPERA_A  = 3'd0,
      ESPERA_B  = 3'd1,
      ESPERA_OP = 3'd2,
      CALCULA   = 3'd3,
      MOSTRA    = 3'd4
   } estado_t;

   localparam logic [2:0] OP_SOMA    = 3'b100;
   localparam logic [2:0] OP_SUB     = 3'b010;
   localparam logic [2:0] OP_MUL     = 3'b001;
   localparam logic [2:0] OP_NENHUMA = 3'b000;

   function automatic logic op_valida(input logic [2:0] op);
      return (op == OP_SOMA) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/detector_borda.sv
// rtl/detector_borda.sv - rising-edge detector for an already debounced level input
module detector_borda (
   input  logic clk,
   input  logic rst,
   input  logic nivel,
   output logic borda
);

   logic anterior;

   // History resets high so a level held through reset never reads as an edge.
   always_ff @(posedge clk) begin
      if (rst) anterior <= 1'b1;
      else     anterior <= nivel;
   end

   assign borda = nivel & ~anterior;

endmodule

// File: rtl/controle_calculadora.sv
// rtl/controle_calculadora.sv - operand/operation entry sequencer and result register for the calculator
module controle_calculadora
   import calc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  entrada,
   input  logic        sinal_entrada,
   input  logic [2:0]  op_entrada,
   input  logic        botao_enter,
   input  logic        botao_limpa,
   output logic [7:0]  a,
   output logic [7:0]  b,
   output logic        sinal_a,
   output logic        sinal_b,
   output logic [2:0]  sel,
   input  logic [15:0] saida_calc,
   input  logic        sinal_calc,
   output logic [15:0] resultado,
   output logic        sinal_resultado,
   output logic        pronto,
   output logic        erro,
   output logic [2:0]  estado
);

   estado_t estado_atual, estado_prox;
   logic    confirma;
   logic    carrega_a, carrega_b, carrega_sel, captura, descarta, pulso_erro;

   detector_borda u_borda (
      .clk   (clk),
      .rst   (rst),
      .nivel (botao_enter),
      .borda (confirma)
   );

   always_ff @(posedge clk) begin
      if (rst) estado_atual <= ESPERA_A;
      else     estado_atual <= estado_prox;
   end

   always_comb begin
      estado_prox = estado_atual;
      carrega_a   = 1'b0;
      carrega_b   = 1'b0;
      carrega_sel = 1'b0;
      captura     = 1'b0;
      descarta    = 1'b0;
      pulso_erro  = 1'b0;
      if (botao_limpa) begin
         estado_prox = ESPERA_A;
         descarta    = 1'b1;
      end else begin
         case (estado_atual)
            ESPERA_A: if (confirma) begin
               carrega_a   = 1'b1;
               estado_prox = ESPERA_B;
            end
            ESPERA_B: if (confirma) begin
               carrega_b   = 1'b1;
               estado_prox = ESPERA_OP;
            end
            ESPERA_OP: if (confirma) begin
               if (op_valida(op_entrada)) begin
                  carrega_sel = 1'b1;
                  estado_prox = CALCULA;
               end else begin
                  pulso_erro  = 1'b1;
               end
            end
            CALCULA: begin
               captura     = 1'b1;
               estado_prox = MOSTRA;
            end
            MOSTRA: if (confirma) begin
               descarta    = 1'b1;
               estado_prox = ESPERA_A;
            end
            default: estado_prox = ESPERA_A;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a               <= 8'd0;
         b               <= 8'd0;
         sinal_a         <= 1'b0;
         sinal_b         <= 1'b0;
         sel             <= OP_NENHUMA;
         resultado       <= 16'd0;
         sinal_resultado <= 1'b0;
         pronto          <= 1'b0;
         erro            <= 1'b0;
      end else begin
         erro <= pulso_erro;
         if (carrega_a) begin
            a       <= entrada;
            sinal_a <= sinal_entrada;
         end
         if (carrega_b) begin
            b       <= entrada;
            sinal_b <= sinal_entrada;
         end
         if (carrega_sel)   sel <= op_entrada;
         else if (descarta) sel <= OP_NENHUMA;
         // A zero magnitude is always shown as positive.
         if (captura) begin
            resultado       <= saida_calc;
            sinal_resultado <= sinal_calc && (saida_calc != 16'd0);
            pronto          <= 1'b1;
         end else if (descarta) begin
            pronto <= 1'b0;
         end
      end
   end

   assign estado = estado_atual;

endmodule

// File: tb/tb_controle_calculadora.sv
// tb/tb_controle_calculadora.sv - self-checking bench for controle_calculadora
module tb_controle_calculadora;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  entrada;
   logic        sinal_entrada;
   logic [2:0]  op_entrada;
   logic        botao_enter;
   logic        botao_limpa;
   logic [7:0]  a, b;
   logic        sinal_a, sinal_b;
   logic [2:0]  sel;
   logic [15:0] saida_calc;
   logic        sinal_calc;
   logic [15:0] resultado;
   logic        sinal_resultado;
   logic        pronto;
   logic        erro;
   logic [2:0]  estado;

   int vetores = 0;
   int erros   = 0;
   bit ativo   = 1'b0;

   always #5 clk = ~clk;

   controle_calculadora dut (
      .clk             (clk),
      .rst             (rst),
      .entrada         (entrada),
      .sinal_entrada   (sinal_entrada),
      .op_entrada      (op_entrada),
      .botao_enter     (botao_enter),
      .botao_limpa     (botao_limpa),
      .a               (a),
      .b               (b),
      .sinal_a         (sinal_a),
      .sinal_b         (sinal_b),
      .sel             (sel),
      .saida_calc      (saida_calc),
      .sinal_calc      (sinal_calc),
      .resultado       (resultado),
      .sinal_resultado (sinal_resultado),
      .pronto          (pronto),
      .erro            (erro),
      .estado          (estado)
   );

   function automatic int valor(input int ma, input bit sa, input int mb, input bit sb, input int op);
      int va, vb;
      va = sa ? -ma : ma;
      vb = sb ? -mb : mb;
      case (op)
         4:       return va + vb;
         2:       return va - vb;
         1:       return va * vb;
         default: return 0;
      endcase
   endfunction

   // Attached calculator; it leaves a stale sign on zero results so normalisation is exercised.
   int cv;
   always_comb begin
      cv         = valor(int'(a), sinal_a, int'(b), sinal_b, int'(sel));
      saida_calc = 16'(cv < 0 ? -cv : cv);
      if (sel == 3'b001)  sinal_calc = sinal_a ^ sinal_b;
      else if (cv == 0)   sinal_calc = sinal_a;
      else                sinal_calc = (cv < 0);
   end

   int m_st, m_a, m_b, m_sel, m_res;
   bit m_sa, m_sb, m_sres, m_pronto, m_erro, m_prev;
   bit m_conf;

   assign m_conf = botao_enter && !m_prev;

   always @(posedge clk) begin
      m_prev <= rst ? 1'b1 : botao_enter;
      m_erro <= 1'b0;
      if (rst) begin
         m_st <= 0; m_a <= 0; m_b <= 0; m_sa <= 0; m_sb <= 0; m_sel <= 0;
         m_res <= 0; m_sres <= 0; m_pronto <= 0;
      end else if (botao_limpa) begin
         m_st <= 0; m_pronto <= 0; m_sel <= 0;
      end else begin
         case (m_st)
            0: if (m_conf) begin m_a <= entrada; m_sa <= sinal_entrada; m_st <= 1; end
            1: if (m_conf) begin m_b <= entrada; m_sb <= sinal_entrada; m_st <= 2; end
            2: if (m_conf) begin
               if (op_entrada == 3'b100 || op_entrada == 3'b010 || op_entrada == 3'b001) begin
                  m_sel <= op_entrada; m_st <= 3;
               end else m_erro <= 1'b1;
            end
            3: begin
               m_res    <= valor(m_a, m_sa, m_b, m_sb, m_sel) < 0 ? -valor(m_a, m_sa, m_b, m_sb, m_sel)
                                                                :  valor(m_a, m_sa, m_b, m_sb, m_sel);
               m_sres   <= valor(m_a, m_sa, m_b, m_sb, m_sel) < 0;
               m_pronto <= 1'b1;
               m_st     <= 4;
            end
            default: if (m_conf) begin m_pronto <= 0; m_sel <= 0; m_st <= 0; end
         endcase
      end
   end

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
      vetores++;
      if (act !== exp) begin
         erros++;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (ativo) begin
         chk("m.estado",          32'(estado),          32'(m_st));
         chk("m.a",               32'(a),               32'(m_a));
         chk("m.b",               32'(b),               32'(m_b));
         chk("m.sinal_a",         32'(sinal_a),         32'(m_sa));
         chk("m.sinal_b",         32'(sinal_b),         32'(m_sb));
         chk("m.sel",             32'(sel),             32'(m_sel));
         chk("m.resultado",       32'(resultado),       32'(m_res));
         chk("m.sinal_resultado", 32'(sinal_resultado), 32'(m_sres));
         chk("m.pronto",          32'(pronto),          32'(m_pronto));
         chk("m.erro",            32'(erro),            32'(m_erro));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic confirma(input logic [7:0] v, input logic s);
      entrada = v; sinal_entrada = s; botao_enter = 1'b1;
      tick();
      botao_enter = 1'b0;
      tick();
   endtask

   task automatic operacao(input logic [2:0] op, input int exp_res, input bit exp_sinal, input string nome);
      op_entrada = op; botao_enter = 1'b1;
      tick();
      chk({nome, ".estado_calc"}, 32'(estado), 32'd3);
      chk({nome, ".pronto_cedo"}, 32'(pronto), 32'd0);
      botao_enter = 1'b0;
      tick();
      chk({nome, ".pronto"},    32'(pronto),          32'd1);
      chk({nome, ".resultado"}, 32'(resultado),       32'(exp_res));
      chk({nome, ".sinal"},     32'(sinal_resultado), 32'(exp_sinal));
      chk({nome, ".estado"},    32'(estado),          32'd4);
   endtask

   task automatic volta();
      botao_enter = 1'b1; tick();
      botao_enter = 1'b0; tick();
   endtask

   initial begin
      rst = 1'b1; entrada = 8'd0; sinal_entrada = 1'b0; op_entrada = 3'b000;
      botao_enter = 1'b1; botao_limpa = 1'b0;
      tick();
      ativo = 1'b1;
      tick();
      chk("reset.estado", 32'(estado), 32'd0);
      chk("reset.sel",    32'(sel),    32'd0);
      rst = 1'b0;
      tick(); tick();
      chk("held_through_reset.estado", 32'(estado), 32'd0);
      botao_enter = 1'b0;
      tick();

      confirma(8'd25, 1'b0);
      chk("s1.estado_b", 32'(estado), 32'd1);
      confirma(8'd10, 1'b1);
      chk("s1.estado_op", 32'(estado), 32'd2);
      operacao(3'b100, 15, 1'b0, "s1");
      volta();
      chk("s1.estado_fim", 32'(estado),    32'd0);
      chk("s1.sel_fim",    32'(sel),       32'd0);
      chk("s1.res_mantido",32'(resultado), 32'd15);

      confirma(8'd12, 1'b1);
      confirma(8'd12, 1'b0);
      operacao(3'b100, 0, 1'b0, "s2");
      volta();

      confirma(8'd200, 1'b0);
      confirma(8'd255, 1'b1);
      operacao(3'b001, 51000, 1'b1, "s3");
      volta();

      confirma(8'd5, 1'b0);
      confirma(8'd3, 1'b0);
      op_entrada = 3'b011; botao_enter = 1'b1;
      tick();
      chk("s4.erro",   32'(erro),   32'd1);
      chk("s4.estado", 32'(estado), 32'd2);
      chk("s4.sel",    32'(sel),    32'd0);
      botao_enter = 1'b0;
      tick();
      chk("s4.erro_fim", 32'(erro), 32'd0);
      operacao(3'b010, 2, 1'b0, "s4");
      volta();

      entrada = 8'd7; sinal_entrada = 1'b0; botao_enter = 1'b1;
      repeat (10) tick();
      chk("s5.estado", 32'(estado), 32'd1);
      chk("s5.a",      32'(a),      32'd7);
      botao_enter = 1'b0;
      tick();
      confirma(8'd9, 1'b1);
      botao_limpa = 1'b1; botao_enter = 1'b1; op_entrada = 3'b100;
      tick();
      chk("s6.estado_limpa", 32'(estado), 32'd0);
      chk("s6.a_mantido",    32'(a),      32'd7);
      botao_limpa = 1'b0; botao_enter = 1'b0;
      tick();

      confirma(8'd0, 1'b0);
      confirma(8'd5, 1'b1);
      operacao(3'b001, 0, 1'b0, "s6z");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("s6.rst_estado", 32'(estado),          32'd0);
      chk("s6.rst_res",    32'(resultado),       32'd0);
      chk("s6.rst_pronto", 32'(pronto),          32'd0);
      chk("s6.rst_a",      32'(a),               32'd0);
      chk("s6.rst_sinal",  32'(sinal_resultado), 32'd0);
      tick();

      confirma(8'd3, 1'b0);
      confirma(8'd4, 1'b0);
      op_entrada = 3'b100; botao_enter = 1'b1;
      tick();
      rst = 1'b1; botao_enter = 1'b0;
      tick();
      rst = 1'b0;
      chk("s7.sem_captura", 32'(resultado), 32'd0);
      chk("s7.pronto",      32'(pronto),    32'd0);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
      $finish;
   end

endmodule
